acc_alu_sequencer: RTL and testbench

Execution stage directly upstream of the 8-bit accumulator register. It takes the current accumulator value and a second operand, and computes the result of one opcode. It drives the accumulator's data input with that result and pulses its write enable for one cycle. Single-cycle ops complete in one cycle; MUL is a multi-cycle shift-add. A Z/C/N flag register is maintained for the control unit.

---
 rtl/acc_alu_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_acc_alu_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_alu_sequencer.sv
// ---------------------------------------------------------------------------
// acc_alu_sequencer
//
// Execution stage sitting in front of the accumulator register. It combines
// the accumulator's current value (acc_in) with a second operand (operand_b)
// according to op_code, drives the result onto acc_data and raises acc_we for
// exactly one cycle so the accumulator captures it. Most operations finish
// in one cycle; MUL is an iterative shift-add taking WIDTH cycles. A Z/C/N
// flag register is kept for the control unit.
//
// Ports:
//   reg_clk    in   clock, rising edge
//   reg_rst    in   synchronous active-high reset
//   op_start   in   request to run op_code (taken only while op_ready=1)
//   op_code    in   [3:0] operation select
//   acc_in     in   [WIDTH-1:0] operand A (accumulator output)
//   operand_b  in   [WIDTH-1:0] operand B
//   op_ready   out  idle and able to take a new op
//   acc_data   out  [WIDTH-1:0] result towards accumulator data_in
//   acc_we     out  one-cycle write strobe towards accumulator reg_en
//   flag_z     out  result is zero
//   flag_c     out  carry / borrow / shifted-out bit / MUL overflow
//   flag_n     out  result MSB
// ---------------------------------------------------------------------------
module acc_alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             reg_clk,
    input  logic             reg_rst,
    input  logic             op_start,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] operand_b,
    output logic             op_ready,
    output logic [WIDTH-1:0] acc_data,
    output logic             acc_we,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_LOAD = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_ADC  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic             accept;
    logic             is_alu_op;
    logic             is_mul_op;

    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic             add_cin;

    logic [2*WIDTH-1:0] mul_mcand;
    logic [WIDTH-1:0]   mul_mplier;
    logic [2*WIDTH-1:0] mul_prod;
    logic [2*WIDTH-1:0] mul_prod_next;
    logic [CW-1:0]      mul_count;
    logic               mul_last;

    // Opcodes 0..9 finish in one cycle, 0xA is the multiplier, and anything
    // above is a NOP that is accepted but leaves the FSM in IDLE.
    assign is_alu_op = (op_code <= OP_SHR);
    assign is_mul_op = (op_code == OP_MUL);
    assign accept    = op_start && op_ready;
    assign mul_last  = (mul_count == CW'(WIDTH - 1));

    // State register; reset pulls the FSM back to IDLE and silently drops
    // any multiply in progress.
    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. op_ready is only offered in IDLE and
    // the write strobe only exists in WB, so each op yields at most one pulse.
    always_comb begin
        state_next = state;
        op_ready   = 1'b0;
        acc_we     = 1'b0;
        case (state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_start) begin
                    if (is_mul_op) begin
                        state_next = MUL;
                    end else if (is_alu_op) begin
                        state_next = WB;
                    end
                end
            end
            MUL: begin
                if (mul_last) begin
                    state_next = WB;
                end
            end
            WB: begin
                acc_we     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Carry-in for ADC is the flag as it stands in the acceptance cycle.
    assign add_cin = (op_code == OP_ADC) ? flag_c : 1'b0;
    assign add_ext = {1'b0, acc_in} + {1'b0, operand_b} + {{WIDTH{1'b0}}, add_cin};
    assign sub_ext = {1'b0, acc_in} - {1'b0, operand_b};

    // Single-cycle result and carry. LOAD keeps the old carry; the logic ops
    // clear it; SUB reports the borrow, which is the wrapped top bit of the
    // extended difference.
    always_comb begin
        alu_result = '0;
        alu_carry  = flag_c;
        case (op_code)
            OP_LOAD: begin
                alu_result = operand_b;
            end
            OP_ADD, OP_ADC: begin
                alu_result = add_ext[WIDTH-1:0];
                alu_carry  = add_ext[WIDTH];
            end
            OP_SUB: begin
                alu_result = sub_ext[WIDTH-1:0];
                alu_carry  = sub_ext[WIDTH];
            end
            OP_AND: begin
                alu_result = acc_in & operand_b;
                alu_carry  = 1'b0;
            end
            OP_OR: begin
                alu_result = acc_in | operand_b;
                alu_carry  = 1'b0;
            end
            OP_XOR: begin
                alu_result = acc_in ^ operand_b;
                alu_carry  = 1'b0;
            end
            OP_NOT: begin
                alu_result = ~acc_in;
                alu_carry  = 1'b0;
            end
            OP_SHL: begin
                alu_result = acc_in << 1;
                alu_carry  = acc_in[WIDTH-1];
            end
            OP_SHR: begin
                alu_result = acc_in >> 1;
                alu_carry  = acc_in[0];
            end
            default: begin
                alu_result = '0;
                alu_carry  = flag_c;
            end
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set. The final step's sum feeds the result directly.
    assign mul_prod_next = mul_prod + (mul_mplier[0] ? mul_mcand : '0);

    // Result, flags and multiplier working registers. acc_data and the flags
    // are only touched when a result is produced, so they hold across MUL
    // iterations and between ops.
    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            acc_data   <= '0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            flag_n     <= 1'b0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_prod   <= '0;
            mul_count  <= '0;
        end else begin
            if (accept && is_alu_op) begin
                acc_data <= alu_result;
                flag_z   <= (alu_result == '0);
                flag_n   <= alu_result[WIDTH-1];
                flag_c   <= alu_carry;
            end
            if (accept && is_mul_op) begin
                mul_mcand  <= {{WIDTH{1'b0}}, acc_in};
                mul_mplier <= operand_b;
                mul_prod   <= '0;
                mul_count  <= '0;
            end
            if (state == MUL) begin
                mul_prod   <= mul_prod_next;
                mul_mcand  <= mul_mcand << 1;
                mul_mplier <= mul_mplier >> 1;
                mul_count  <= mul_count + CW'(1);
                if (mul_last) begin
                    acc_data <= mul_prod_next[WIDTH-1:0];
                    flag_z   <= (mul_prod_next[WIDTH-1:0] == '0);
                    flag_n   <= mul_prod_next[WIDTH-1];
                    flag_c   <= |mul_prod_next[2*WIDTH-1:WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_acc_alu_sequencer
//
// Self-checking bench for acc_alu_sequencer. A behavioural model computes
// each op's result and flags with plain integer arithmetic; every scenario
// task drives the DUT and compares what it observes against that model or
// against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_acc_alu_sequencer;

    localparam int W = 8;

    logic         reg_clk;
    logic         reg_rst;
    logic         op_start;
    logic [3:0]   op_code;
    logic [W-1:0] acc_in;
    logic [W-1:0] operand_b;
    logic         op_ready;
    logic [W-1:0] acc_data;
    logic         acc_we;
    logic         flag_z;
    logic         flag_c;
    logic         flag_n;

    int n_checks;
    int n_fail;

    // Reference model state: what the accumulator result and flags should be.
    logic [W-1:0] m_acc;
    logic         m_z;
    logic         m_c;
    logic         m_n;
    int           m_lat;

    // What one op looked like from the outside over its observation window.
    typedef struct packed {
        int           wb_offset;
        int           we_pulses;
        int           ready_low;
        logic         held;
        logic         ready_start;
        logic         ready_after;
        logic [W-1:0] data;
        logic         z;
        logic         c;
        logic         n;
    } obs_t;

    acc_alu_sequencer #(.WIDTH(W)) dut (
        .reg_clk   (reg_clk),
        .reg_rst   (reg_rst),
        .op_start  (op_start),
        .op_code   (op_code),
        .acc_in    (acc_in),
        .operand_b (operand_b),
        .op_ready  (op_ready),
        .acc_data  (acc_data),
        .acc_we    (acc_we),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_n    (flag_n)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        reg_clk = 1'b0;
        forever #5 reg_clk = ~reg_clk;
    end

    // Behavioural reference: applies one op to the model state using whole
    // integer arithmetic and reports how many cycles until the write.
    task automatic model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned md;
        longint unsigned av;
        longint unsigned bv;
        longint unsigned full;
        longint unsigned r;
        logic            c;
        logic            wr;
        md   = longint'(1) << W;
        av   = a;
        bv   = b;
        r    = 0;
        full = 0;
        c    = m_c;
        wr   = 1'b1;
        case (op)
            4'h0: r = bv;
            4'h1: begin full = av + bv; r = full % md; c = (full >= md); end
            4'h2: begin full = av + bv + m_c; r = full % md; c = (full >= md); end
            4'h3: begin r = (av + md - bv) % md; c = (av < bv); end
            4'h4: begin r = av & bv; c = 1'b0; end
            4'h5: begin r = av | bv; c = 1'b0; end
            4'h6: begin r = av ^ bv; c = 1'b0; end
            4'h7: begin r = (md - 1) - av; c = 1'b0; end
            4'h8: begin full = av * 2; r = full % md; c = (full >= md); end
            4'h9: begin r = av / 2; c = (av % 2 == 1); end
            4'hA: begin full = av * bv; r = full % md; c = (full >= md); end
            default: wr = 1'b0;
        endcase
        if (wr) begin
            m_acc = r[W-1:0];
            m_c   = c;
            m_z   = (r == 0);
            m_n   = (r >= md / 2);
            m_lat = (op == 4'hA) ? W + 1 : 1;
        end else begin
            m_lat = -1;
        end
    endtask

    // Drives one op in cycle N and watches W+3 following cycles, scrambling
    // the data inputs afterwards so late sampling would be visible.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output obs_t o);
        logic [W-1:0] pre;
        @(negedge reg_clk);
        o.ready_start = op_ready;
        pre           = acc_data;
        op_start      = 1'b1;
        op_code       = op;
        acc_in        = a;
        operand_b     = b;
        o.wb_offset   = -1;
        o.we_pulses   = 0;
        o.ready_low   = 0;
        o.held        = 1'b1;
        o.data        = '0;
        o.z           = 1'b0;
        o.c           = 1'b0;
        o.n           = 1'b0;
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge reg_clk);
            op_start  = 1'b0;
            op_code   = 4'($urandom);
            acc_in    = W'($urandom);
            operand_b = W'($urandom);
            if (acc_we) begin
                o.we_pulses++;
                if (o.wb_offset < 0) begin
                    o.wb_offset = k;
                    o.data      = acc_data;
                    o.z         = flag_z;
                    o.c         = flag_c;
                    o.n         = flag_n;
                end
            end else if (o.wb_offset < 0 && acc_data !== pre) begin
                o.held = 1'b0;
            end
            if (!op_ready) o.ready_low++;
        end
        o.ready_after = op_ready;
        if (o.wb_offset < 0) begin
            o.data = acc_data;
            o.z    = flag_z;
            o.c    = flag_c;
            o.n    = flag_n;
        end
    endtask

    // Reset state: everything cleared, op_ready offered, no write strobe.
    task automatic test_reset();
        op_start  = 1'b0;
        op_code   = 4'h0;
        acc_in    = '0;
        operand_b = '0;
        reg_rst   = 1'b1;
        repeat (2) @(negedge reg_clk);
        n_checks++; if (acc_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_data: got %h want 00", acc_data); end
        n_checks++; if ({flag_z, flag_c, flag_n} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b want 000", {flag_z, flag_c, flag_n}); end
        n_checks++; if (acc_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_we: got %b want 0", acc_we); end
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 1", op_ready); end
        reg_rst = 1'b0;
        m_acc = '0; m_z = 1'b0; m_c = 1'b0; m_n = 1'b0;
    endtask

    // ADD with carry out, including the exact handshake timing.
    task automatic test_add();
        obs_t o;
        applyStimulus(4'h1, 8'hF0, 8'h20, o);
        model_op(4'h1, 8'hF0, 8'h20);
        n_checks++; if (o.ready_start !== 1'b1) begin n_fail++; $display("[TB] FAIL add_ready_start: got %b want 1", o.ready_start); end
        n_checks++; if (o.wb_offset != 1) begin n_fail++; $display("[TB] FAIL add_wb_cycle: got %0d want 1", o.wb_offset); end
        n_checks++; if (o.data !== 8'h10) begin n_fail++; $display("[TB] FAIL add_data: got %h want 10", o.data); end
        n_checks++; if ({o.z, o.c, o.n} !== 3'b010) begin n_fail++; $display("[TB] FAIL add_flags_zcn: got %b want 010", {o.z, o.c, o.n}); end
        n_checks++; if (o.ready_low != 1) begin n_fail++; $display("[TB] FAIL add_busy_cycles: got %0d want 1", o.ready_low); end
        n_checks++; if (o.we_pulses != 1) begin n_fail++; $display("[TB] FAIL add_we_pulses: got %0d want 1", o.we_pulses); end
    endtask

    // SUB zero result, SUB with borrow, then ADC consuming that borrow.
    task automatic test_sub_adc();
        obs_t o;
        applyStimulus(4'h3, 8'h05, 8'h05, o);
        model_op(4'h3, 8'h05, 8'h05);
        n_checks++; if (o.data !== 8'h00) begin n_fail++; $display("[TB] FAIL sub_zero_data: got %h want 00", o.data); end
        n_checks++; if ({o.z, o.c, o.n} !== 3'b100) begin n_fail++; $display("[TB] FAIL sub_zero_flags_zcn: got %b want 100", {o.z, o.c, o.n}); end
        applyStimulus(4'h3, 8'h03, 8'h05, o);
        model_op(4'h3, 8'h03, 8'h05);
        n_checks++; if (o.data !== 8'hFE) begin n_fail++; $display("[TB] FAIL sub_borrow_data: got %h want fe", o.data); end
        n_checks++; if ({o.z, o.c, o.n} !== 3'b011) begin n_fail++; $display("[TB] FAIL sub_borrow_flags_zcn: got %b want 011", {o.z, o.c, o.n}); end
        applyStimulus(4'h2, 8'h01, 8'h01, o);
        model_op(4'h2, 8'h01, 8'h01);
        n_checks++; if (o.data !== 8'h03) begin n_fail++; $display("[TB] FAIL adc_data: got %h want 03", o.data); end
        n_checks++; if ({o.z, o.c, o.n} !== 3'b000) begin n_fail++; $display("[TB] FAIL adc_flags_zcn: got %b want 000", {o.z, o.c, o.n}); end
    endtask

    // Multi-cycle multiply: latency, busy window, held output, overflow flag.
    task automatic test_mul();
        obs_t o;
        applyStimulus(4'hA, 8'h0C, 8'h0B, o);
        model_op(4'hA, 8'h0C, 8'h0B);
        n_checks++; if (o.wb_offset != W + 1) begin n_fail++; $display("[TB] FAIL mul_wb_cycle: got %0d want %0d", o.wb_offset, W + 1); end
        n_checks++; if (o.ready_low != W + 1) begin n_fail++; $display("[TB] FAIL mul_busy_cycles: got %0d want %0d", o.ready_low, W + 1); end
        n_checks++; if (o.held !== 1'b1) begin n_fail++; $display("[TB] FAIL mul_data_held: got %b want 1", o.held); end
        n_checks++; if (o.data !== 8'h84) begin n_fail++; $display("[TB] FAIL mul_data: got %h want 84", o.data); end
        n_checks++; if (o.c !== 1'b0) begin n_fail++; $display("[TB] FAIL mul_carry: got %b want 0", o.c); end
        applyStimulus(4'hA, 8'h20, 8'h10, o);
        model_op(4'hA, 8'h20, 8'h10);
        n_checks++; if (o.data !== 8'h00) begin n_fail++; $display("[TB] FAIL mul_ovf_data: got %h want 00", o.data); end
        n_checks++; if ({o.z, o.c} !== 2'b11) begin n_fail++; $display("[TB] FAIL mul_ovf_flags_zc: got %b want 11", {o.z, o.c}); end
        n_checks++; if (o.we_pulses != 1) begin n_fail++; $display("[TB] FAIL mul_we_pulses: got %0d want 1", o.we_pulses); end
    endtask

    // Shifts and a logic op that clears carry.
    task automatic test_shift_logic();
        obs_t o;
        applyStimulus(4'h8, 8'h81, 8'h00, o);
        model_op(4'h8, 8'h81, 8'h00);
        n_checks++; if ({o.data, o.c} !== {8'h02, 1'b1}) begin n_fail++; $display("[TB] FAIL shl_data_c: got %h/%b want 02/1", o.data, o.c); end
        applyStimulus(4'h9, 8'h81, 8'h00, o);
        model_op(4'h9, 8'h81, 8'h00);
        n_checks++; if ({o.data, o.c} !== {8'h40, 1'b1}) begin n_fail++; $display("[TB] FAIL shr_data_c: got %h/%b want 40/1", o.data, o.c); end
        applyStimulus(4'h4, 8'hF0, 8'h0F, o);
        model_op(4'h4, 8'hF0, 8'h0F);
        n_checks++; if ({o.data, o.z, o.c} !== {8'h00, 1'b1, 1'b0}) begin n_fail++; $display("[TB] FAIL and_data_zc: got %h/%b%b want 00/10", o.data, o.z, o.c); end
    endtask

    // A start request during a MUL must be dropped entirely.
    task automatic test_busy_ignore();
        int           pulses;
        logic [W-1:0] wdata;
        pulses = 0;
        wdata  = '0;
        @(negedge reg_clk);
        op_start = 1'b1; op_code = 4'hA; acc_in = 8'h0C; operand_b = 8'h0B;
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge reg_clk);
            if (k == 3) begin
                op_start = 1'b1; op_code = 4'h1; acc_in = 8'h01; operand_b = 8'h01;
            end else begin
                op_start = 1'b0;
            end
            if (acc_we) begin
                pulses++;
                wdata = acc_data;
            end
        end
        model_op(4'hA, 8'h0C, 8'h0B);
        n_checks++; if (pulses != 1) begin n_fail++; $display("[TB] FAIL busy_we_pulses: got %0d want 1", pulses); end
        n_checks++; if (wdata !== m_acc) begin n_fail++; $display("[TB] FAIL busy_result: got %h want %h", wdata, m_acc); end
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL busy_ready_after: got %b want 1", op_ready); end
    endtask

    // Reset mid-MUL aborts without a write; reset beats a same-cycle start;
    // a NOP opcode never drops op_ready.
    task automatic test_reset_abort_nop();
        int   pulses;
        obs_t o;
        pulses = 0;
        @(negedge reg_clk);
        op_start = 1'b1; op_code = 4'hA; acc_in = 8'hFF; operand_b = 8'hFF;
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge reg_clk);
            op_start = 1'b0;
            reg_rst  = (k == 4);
            if (acc_we) pulses++;
            if (k == 5) begin
                n_checks++; if ({acc_data, flag_z, flag_c, flag_n} !== {8'h00, 3'b000}) begin n_fail++; $display("[TB] FAIL abort_cleared: got %h/%b%b%b want 00/000", acc_data, flag_z, flag_c, flag_n); end
                n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_ready: got %b want 1", op_ready); end
            end
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("[TB] FAIL abort_we_pulses: got %0d want 0", pulses); end
        m_acc = '0; m_z = 1'b0; m_c = 1'b0; m_n = 1'b0;

        @(negedge reg_clk);
        reg_rst = 1'b1; op_start = 1'b1; op_code = 4'h0; acc_in = 8'h11; operand_b = 8'h77;
        @(negedge reg_clk);
        reg_rst = 1'b0; op_start = 1'b0;
        n_checks++; if ({op_ready, acc_we} !== 2'b10) begin n_fail++; $display("[TB] FAIL rst_start_handshake: got %b want 10", {op_ready, acc_we}); end
        @(negedge reg_clk);
        n_checks++; if ({acc_we, acc_data} !== {1'b0, 8'h00}) begin n_fail++; $display("[TB] FAIL rst_start_dropped: got %b/%h want 0/00", acc_we, acc_data); end

        applyStimulus(4'hC, 8'h5A, 8'hA5, o);
        model_op(4'hC, 8'h5A, 8'hA5);
        n_checks++; if (o.we_pulses != 0) begin n_fail++; $display("[TB] FAIL nop_we_pulses: got %0d want 0", o.we_pulses); end
        n_checks++; if (o.ready_low != 0) begin n_fail++; $display("[TB] FAIL nop_busy_cycles: got %0d want 0", o.ready_low); end
        n_checks++; if (o.data !== m_acc) begin n_fail++; $display("[TB] FAIL nop_data: got %h want %h", o.data, m_acc); end
    endtask

    // Random opcode/operand stream compared against the model.
    task automatic test_random();
        obs_t         o;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = W'($urandom);
            b  = W'($urandom);
            applyStimulus(op, a, b, o);
            model_op(op, a, b);
            n_checks++; if (o.wb_offset != m_lat) begin n_fail++; $display("[TB] FAIL rand_wb_cycle op=%h: got %0d want %0d", op, o.wb_offset, m_lat); end
            n_checks++; if (o.we_pulses != ((m_lat < 0) ? 0 : 1)) begin n_fail++; $display("[TB] FAIL rand_we_pulses op=%h: got %0d", op, o.we_pulses); end
            n_checks++; if (o.ready_low != ((m_lat < 0) ? 0 : m_lat)) begin n_fail++; $display("[TB] FAIL rand_busy op=%h: got %0d want %0d", op, o.ready_low, m_lat); end
            n_checks++; if (o.data !== m_acc) begin n_fail++; $display("[TB] FAIL rand_data op=%h a=%h b=%h: got %h want %h", op, a, b, o.data, m_acc); end
            n_checks++; if ({o.z, o.c, o.n} !== {m_z, m_c, m_n}) begin n_fail++; $display("[TB] FAIL rand_flags op=%h a=%h b=%h: got %b want %b", op, a, b, {o.z, o.c, o.n}, {m_z, m_c, m_n}); end
            n_checks++; if (o.held !== 1'b1 || o.ready_after !== 1'b1) begin n_fail++; $display("[TB] FAIL rand_hold_ready op=%h: got %b%b want 11", op, o.held, o.ready_after); end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_lat    = -1;
        test_reset();
        test_add();
        test_sub_adc();
        test_mul();
        test_shift_logic();
        test_busy_ignore();
        test_reset_abort_nop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
